// File: rtl/regfile_wb_arbiter.sv
// Purpose : arbitrates the single register-file write port between ALU and load writeback, with a load scoreboard.
// Latency : accept -> rf_we/rf_waddr/rf_wdata registered one edge later; scoreboard/busy/ready are combinational from state.
// Backpressure: valid/ready per requester; a loser sees ready=0 and holds its payload; ALU is forced to win after STARVE_LIMIT stalls.
//
// Ports:
//   clk, reset_n                       clock (rising edge), async active-low reset
//   alu_valid/alu_ready/alu_rd/alu_data ALU writeback request
//   mem_valid/mem_ready/mem_rd/mem_data load-return writeback request
//   iss_valid/iss_ready/iss_rd          load issue; marks iss_rd pending (ready=0 if already pending)
//   rs1_addr/rs2_addr, rs1_busy/rs2_busy decode hazard query against the scoreboard (x0 never busy)
//   rf_we/rf_waddr/rf_wdata             registered register-file write port
//   fwd1_hit/fwd2_hit/fwd_data          write-cycle bypass to decode, present when WB_BYPASS_EN is defined
//                                       (tied to 0 otherwise)
// Optional feature macro: WB_BYPASS_EN

module regfile_wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            iss_valid,
    output logic            iss_ready,
    input  logic [4:0]      iss_rd,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            fwd1_hit,
    output logic            fwd2_hit,
    output logic [XLEN-1:0] fwd_data
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic {
        PRIO_MEM = 1'b0,
        PRIO_ALU = 1'b1
    } prio_t;

    prio_t           prio_q, prio_d;
    logic [3:0]      starve_q, starve_d;
    logic [31:0]     pending_q, pending_d;
    logic [31:0]     set_vec, clr_vec;
    logic            alu_acc, mem_acc, any_acc;
    logic [4:0]      wr_rd;
    logic [XLEN-1:0] wr_data;

    // Grant: a lone requester always wins; under contention the priority state decides.
    always_comb begin
        alu_ready = alu_valid & (~mem_valid | (prio_q == PRIO_ALU));
        mem_ready = mem_valid & (~alu_valid | (prio_q == PRIO_MEM));
    end

    assign alu_acc = alu_valid & alu_ready;
    assign mem_acc = mem_valid & mem_ready;
    assign any_acc = alu_acc | mem_acc;
    assign wr_rd   = alu_acc ? alu_rd   : mem_rd;
    assign wr_data = alu_acc ? alu_data : mem_data;

    // Priority FSM and starvation counter.
    always_comb begin
        prio_d   = prio_q;
        starve_d = starve_q;
        if (alu_acc) begin
            starve_d = 4'd0;
        end else if (alu_valid && (starve_q != 4'hF)) begin
            starve_d = starve_q + 4'd1;
        end
        // ALU keeps the forced priority only until it has been served once.
        if (alu_acc && (prio_q == PRIO_ALU)) begin
            prio_d = PRIO_MEM;
        end else if (starve_d >= LIMIT) begin
            prio_d = PRIO_ALU;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio_q   <= PRIO_MEM;
            starve_q <= 4'd0;
        end else begin
            prio_q   <= prio_d;
            starve_q <= starve_d;
        end
    end

    // Write stage: x0 targets are accepted but never raise the write enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= '0;
        end else begin
            rf_we <= any_acc && (wr_rd != 5'd0);
            if (any_acc) begin
                rf_waddr <= wr_rd;
                rf_wdata <= wr_data;
            end
        end
    end

    // Scoreboard: one outstanding load per rd; a same-cycle set overrides a clear.
    assign iss_ready = ~pending_q[iss_rd];

    always_comb begin
        set_vec = 32'd0;
        clr_vec = 32'd0;
        if (iss_valid && iss_ready) begin
            set_vec = 32'd1 << iss_rd;
        end
        if (mem_acc) begin
            clr_vec = 32'd1 << mem_rd;
        end
        pending_d = ((pending_q & ~clr_vec) | set_vec) & 32'hFFFF_FFFE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= 32'd0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Bit 0 is never set, so x0 reads as not busy without a special case.
    assign rs1_busy = pending_q[rs1_addr];
    assign rs2_busy = pending_q[rs2_addr];

`ifdef WB_BYPASS_EN
    assign fwd1_hit = rf_we & (rf_waddr == rs1_addr) & (rs1_addr != 5'd0);
    assign fwd2_hit = rf_we & (rf_waddr == rs2_addr) & (rs2_addr != 5'd0);
    assign fwd_data = rf_wdata;
`else
    assign fwd1_hit = 1'b0;
    assign fwd2_hit = 1'b0;
    assign fwd_data = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        reset_n;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid, mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        iss_valid, iss_ready;
    logic [4:0]  iss_rd;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        rs1_busy, rs2_busy;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        fwd1_hit, fwd2_hit;
    logic [31:0] fwd_data;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rd(iss_rd),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd_data(fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
        iss_valid = 1'b0; iss_rd = 5'd0;
        rs1_addr  = 5'd0; rs2_addr = 5'd0;
        #2;
        chk("rst_we", {31'd0, rf_we}, 32'd0);
        chk("rst_waddr", {27'd0, rf_waddr}, 32'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        chk("rst_alu_ready_idle", {31'd0, alu_ready}, 32'd0);
        tick; tick;
        reset_n = 1'b1;
        tick;

        // Lone ALU request is accepted at once and written one edge later.
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_00AA;
        #1;
        chk("lone_alu_ready", {31'd0, alu_ready}, 32'd1);
        chk("lone_alu_mem_ready", {31'd0, mem_ready}, 32'd0);
        tick;
        alu_valid = 1'b0;
        chk("lone_alu_we", {31'd0, rf_we}, 32'd1);
        chk("lone_alu_waddr", {27'd0, rf_waddr}, 32'd5);
        chk("lone_alu_wdata", rf_wdata, 32'h0000_00AA);
        tick;
        chk("idle_we", {31'd0, rf_we}, 32'd0);
        chk("idle_waddr_hold", {27'd0, rf_waddr}, 32'd5);

        // Contention: mem wins four cycles, then ALU wins the fifth, repeating.
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA10;
        mem_valid = 1'b1; mem_rd = 5'd11; mem_data = 32'hB11;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("cont_alu_ready_%0d", i), {31'd0, alu_ready}, (i % 5 == 4) ? 32'd1 : 32'd0);
            chk($sformatf("cont_mem_ready_%0d", i), {31'd0, mem_ready}, (i % 5 == 4) ? 32'd0 : 32'd1);
            tick;
            chk($sformatf("cont_waddr_%0d", i), {27'd0, rf_waddr}, (i % 5 == 4) ? 32'd10 : 32'd11);
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        tick;

        // Scoreboard set, query, clear, and same-cycle set+clear.
        iss_valid = 1'b1; iss_rd = 5'd7; rs1_addr = 5'd7; rs2_addr = 5'd7;
        #1;
        chk("sb_iss_ready_free", {31'd0, iss_ready}, 32'd1);
        chk("sb_busy_before", {31'd0, rs1_busy}, 32'd0);
        tick;
        iss_valid = 1'b0;
        #1;
        chk("sb_rs1_busy", {31'd0, rs1_busy}, 32'd1);
        chk("sb_rs2_busy", {31'd0, rs2_busy}, 32'd1);
        chk("sb_iss_ready_pending", {31'd0, iss_ready}, 32'd0);
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h77;
        #1;
        chk("sb_mem_ready", {31'd0, mem_ready}, 32'd1);
        tick;
        mem_valid = 1'b0;
        #1;
        chk("sb_busy_cleared", {31'd0, rs1_busy}, 32'd0);
        chk("sb_iss_ready_again", {31'd0, iss_ready}, 32'd1);
        chk("sb_load_waddr", {27'd0, rf_waddr}, 32'd7);
        chk("sb_load_wdata", rf_wdata, 32'h77);
        mem_valid = 1'b1; iss_valid = 1'b1;
        tick;
        mem_valid = 1'b0; iss_valid = 1'b0;
        #1;
        chk("sb_set_wins", {31'd0, rs1_busy}, 32'd1);
        chk("sb_nonpending_written", {31'd0, rf_we}, 32'd1);

        // x0: accepted but not written; never pending.
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
        #1;
        chk("x0_alu_ready", {31'd0, alu_ready}, 32'd1);
        tick;
        alu_valid = 1'b0;
        chk("x0_we", {31'd0, rf_we}, 32'd0);
        iss_valid = 1'b1; iss_rd = 5'd0; rs1_addr = 5'd0;
        tick;
        iss_valid = 1'b0;
        #1;
        chk("x0_busy", {31'd0, rs1_busy}, 32'd0);
        chk("x0_iss_ready", {31'd0, iss_ready}, 32'd1);

        // Write-cycle bypass.
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h1234;
        tick;
        alu_valid = 1'b0; rs1_addr = 5'd3; rs2_addr = 5'd4;
        #1;
        chk("byp_we", {31'd0, rf_we}, 32'd1);
`ifdef WB_BYPASS_EN
        chk("byp_fwd1", {31'd0, fwd1_hit}, 32'd1);
        chk("byp_data", fwd_data, 32'h1234);
`else
        chk("byp_fwd1", {31'd0, fwd1_hit}, 32'd0);
        chk("byp_data", fwd_data, 32'd0);
`endif
        chk("byp_fwd2", {31'd0, fwd2_hit}, 32'd0);
        tick;

        // Reset mid-traffic: pending load on rd 9 and a registered write in flight.
        iss_valid = 1'b1; iss_rd = 5'd9;
        tick;
        iss_valid = 1'b0; rs1_addr = 5'd9;
        alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hC12;
        tick;
        chk("mid_pre_we", {31'd0, rf_we}, 32'd1);
        chk("mid_pre_busy", {31'd0, rs1_busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_we", {31'd0, rf_we}, 32'd0);
        chk("mid_rst_busy", {31'd0, rs1_busy}, 32'd0);
        for (int r = 0; r < 32; r++) begin
            iss_rd = 5'(r);
            #1;
            chk($sformatf("mid_rst_iss_ready_%0d", r), {31'd0, iss_ready}, 32'd1);
        end
        alu_valid = 1'b0;
        reset_n = 1'b1;
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
